// File: rtl/debug_tx_scheduler_pkg.sv
// debug_tx_scheduler_pkg: shared debug-unit constants (requester ids, command bytes, scheduler states)
// Build option: DEBUG_TX_CHECKSUM_EN adds the CSUM/CSUM_WAIT states.
package debug_tx_scheduler_pkg;
  localparam int REQ_PC = 0;
  localparam int REQ_BR = 1;
  localparam int REQ_DM = 2;
  localparam logic [7:0] CMD_DUMP_PC = 8'h50;
  localparam logic [7:0] CMD_DUMP_BR = 8'h52;
  localparam logic [7:0] CMD_DUMP_DM = 8'h4d;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    WAIT = 3'd2,
`ifdef DEBUG_TX_CHECKSUM_EN
    CSUM = 3'd3,
    CSUM_WAIT = 3'd4,
`endif
    ACK = 3'd5
  } state_t;
endpackage

// File: rtl/debug_tx_scheduler_rr_arbiter.sv
// debug_tx_scheduler_rr_arbiter: combinational round-robin arbiter for any shared debug resource
// Ports: req (per-requester request), ptr (highest-priority index), grant (one-hot, 0 when no req).
module debug_tx_scheduler_rr_arbiter #(
  parameter int N = 3,
  parameter int NB_PTR = 2
) (
  input  logic [N-1:0]      req,
  input  logic [NB_PTR-1:0] ptr,
  output logic [N-1:0]      grant
);
  int k;
  // Walk from lowest to highest priority so the requester closest to ptr overwrites last.
  always_comb begin
    grant = '0;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      grant = |(req & (N'(1) << k)) ? N'(1) << k : grant;
    end
  end
endmodule

// File: rtl/debug_tx_scheduler.sv
// debug_tx_scheduler: round-robin sharing of one UART TX among debug word dumpers, MSB byte first
// Ports: i_clock/i_reset (sync, active high); i_req/i_word/i_len flattened requester inputs;
//   o_ready one-hot accept; o_ack per-requester done pulse; o_tx_data/o_tx_start/i_tx_done UART TX
//   handshake; o_busy/o_state debug status.
// Build option: DEBUG_TX_CHECKSUM_EN appends an XOR checksum byte after each word.
module debug_tx_scheduler
  import debug_tx_scheduler_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32,
  parameter int NB_LEN = 2,
  parameter int NB_STATE = 3
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_WORD-1:0] i_word,
  input  logic [N_REQ*NB_LEN-1:0]  i_len,
  output logic [N_REQ-1:0]         o_ready,
  output logic [N_REQ-1:0]         o_ack,
  output logic [NB_DATA-1:0]       o_tx_data,
  output logic                     o_tx_start,
  input  logic                     i_tx_done,
  output logic                     o_busy,
  output logic [NB_STATE-1:0]      o_state
);
  localparam int NB_IDX = N_REQ > 1 ? $clog2(N_REQ) : 1;
`ifdef DEBUG_TX_CHECKSUM_EN
  localparam state_t AFTER_LAST = CSUM;
`else
  localparam state_t AFTER_LAST = ACK;
`endif
  state_t state, next;
  logic [NB_IDX-1:0] ptr, idx, sel;
  logic [NB_WORD-1:0] word;
  logic [NB_LEN-1:0] len, bidx, sh;
  logic [N_REQ-1:0] grant;
  logic [NB_DATA-1:0] cur;
  logic accept, last;
`ifdef DEBUG_TX_CHECKSUM_EN
  logic [NB_DATA-1:0] csum;
`endif
  debug_tx_scheduler_rr_arbiter #(.N(N_REQ), .NB_PTR(NB_IDX)) u_arb (
    .req(i_req),
    .ptr(ptr),
    .grant(grant)
  );
  assign o_ready = state == IDLE ? grant : '0;
  assign accept = |(i_req & o_ready);
  always_comb begin
    sel = '0;
    for (int k = 0; k < N_REQ; k++) sel = grant[k] ? NB_IDX'(k) : sel;
  end
  // bidx counts bytes sent; the byte lane counts down from len so the MSB goes first.
  assign sh = len - bidx;
  assign cur = NB_DATA'(word >> (NB_DATA * int'(sh)));
  assign last = bidx == len;
  assign o_busy = state != IDLE;
  assign o_state = NB_STATE'(state);
  always_comb begin
    next = state;
    o_tx_start = 1'b0;
    o_tx_data = '0;
    o_ack = '0;
    case (state)
      IDLE: next = accept ? SEND : IDLE;
      SEND: begin
        next = WAIT;
        o_tx_start = 1'b1;
        o_tx_data = cur;
      end
      WAIT: begin
        next = !i_tx_done ? WAIT : last ? AFTER_LAST : SEND;
        o_tx_data = cur;
      end
`ifdef DEBUG_TX_CHECKSUM_EN
      CSUM: begin
        next = CSUM_WAIT;
        o_tx_start = 1'b1;
        o_tx_data = csum;
      end
      CSUM_WAIT: begin
        next = i_tx_done ? ACK : CSUM_WAIT;
        o_tx_data = csum;
      end
`endif
      ACK: begin
        next = IDLE;
        o_ack = N_REQ'(1) << idx;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      ptr <= '0;
      idx <= '0;
      word <= '0;
      len <= '0;
      bidx <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      state <= next;
      if (accept) begin
        idx <= sel;
        word <= NB_WORD'(i_word >> (NB_WORD * int'(sel)));
        len <= NB_LEN'(i_len >> (NB_LEN * int'(sel)));
        bidx <= '0;
      end
      if (state == WAIT && i_tx_done && !last) bidx <= bidx + 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
      if (accept) csum <= '0;
      else if (state == WAIT && i_tx_done) csum <= csum ^ cur;
`endif
      if (state == ACK) ptr <= idx == NB_IDX'(N_REQ - 1) ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_debug_tx_scheduler.sv
// tb_debug_tx_scheduler: scoreboard bench for debug_tx_scheduler (honours DEBUG_TX_CHECKSUM_EN)
module tb_debug_tx_scheduler;
  logic clk = 1'b0;
  logic i_reset;
  logic [2:0] i_req;
  logic [95:0] i_word;
  logic [5:0] i_len;
  logic [2:0] o_ready, o_ack;
  logic [7:0] o_tx_data;
  logic o_tx_start, o_busy;
  logic i_tx_done;
  logic [2:0] o_state;
  logic done_uart = 1'b0, stray = 1'b0, uart_on = 1'b1;
  int checks = 0, failures = 0;
  int cyc = 0, done_cyc = -1;
  logic [7:0] exp_b[$];
  logic [2:0] exp_a[$];
  logic [7:0] last_b = 8'h00;

  assign i_tx_done = done_uart | stray;

  debug_tx_scheduler dut (
    .i_clock(clk), .i_reset(i_reset), .i_req(i_req), .i_word(i_word), .i_len(i_len),
    .o_ready(o_ready), .o_ack(o_ack), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .i_tx_done(i_tx_done), .o_busy(o_busy), .o_state(o_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (i_tx_done) done_cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h expected=nothing", nm, act);
  endtask

  // UART model: finishes each byte two cycles after its start pulse.
  initial begin
    @(negedge clk);
    forever begin
      if (uart_on && o_tx_start) begin
        repeat (2) @(negedge clk);
        done_uart = 1'b1;
        @(negedge clk);
        done_uart = 1'b0;
      end else @(negedge clk);
    end
  end

  // Monitor: pops the scoreboard on every start pulse and ack pulse.
  initial forever begin
    @(negedge clk);
    if (o_tx_start) begin
      if (exp_b.size() == 0) unexpected("tx_start", {24'h0, o_tx_data});
      else begin
        last_b = exp_b.pop_front();
        chk("tx_byte", {24'h0, o_tx_data}, {24'h0, last_b});
      end
    end
    if (o_state == 3'd2 || o_state == 3'd4) chk("tx_hold", {24'h0, o_tx_data}, {24'h0, last_b});
    if (o_ack != 3'b000) begin
      if (exp_a.size() == 0) unexpected("ack", {29'h0, o_ack});
      else chk("ack", {29'h0, o_ack}, {29'h0, exp_a.pop_front()});
      chk("ack_latency", cyc, done_cyc);
    end
  end

  task automatic set_word(input int k, input logic [31:0] w, input logic [1:0] len);
    i_word[k*32 +: 32] = w;
    i_len[k*2 +: 2] = len;
  endtask

  task automatic push_word(input logic [31:0] w, input int len, input logic [2:0] ack);
    logic [7:0] b, cs;
    cs = 8'h00;
    for (int i = len; i >= 0; i--) begin
      b = w[8*i +: 8];
      exp_b.push_back(b);
      cs = cs ^ b;
    end
`ifdef DEBUG_TX_CHECKSUM_EN
    exp_b.push_back(cs);
`endif
    exp_a.push_back(ack);
  endtask

  // Drops each accepted request and scrambles its word to prove the in-flight copy is latched.
  task automatic run(input string nm);
    logic [2:0] acc;
    int n = 0;
    while ((exp_b.size() != 0 || exp_a.size() != 0 || i_req != 3'b000 || o_busy) && n < 2000) begin
      #1 acc = i_req & o_ready;
      @(negedge clk);
      if (acc != 3'b000) chk({nm, "_start_latency"}, {31'h0, o_tx_start}, 32'h1);
      for (int k = 0; k < 3; k++)
        if (acc[k]) begin
          i_word[k*32 +: 32] = ~i_word[k*32 +: 32];
          i_len[k*2 +: 2] = ~i_len[k*2 +: 2];
        end
      i_req = i_req & ~acc;
      n++;
    end
    if (n >= 2000) unexpected({nm, "_timeout"}, exp_b.size() + exp_a.size());
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    while (!o_tx_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) unexpected({nm, "_no_start"}, 0);
  endtask

  task automatic pulse_done();
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_state"}, {29'h0, o_state}, 32'h0);
    chk({nm, "_busy"}, {31'h0, o_busy}, 32'h0);
    chk({nm, "_start"}, {31'h0, o_tx_start}, 32'h0);
    chk({nm, "_ack"}, {29'h0, o_ack}, 32'h0);
    chk({nm, "_data"}, {24'h0, o_tx_data}, 32'h0);
    chk({nm, "_ready"}, {29'h0, o_ready}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1;
    i_req = 3'b000;
    i_word = '0;
    i_len = '0;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    i_reset = 1'b0;
    @(negedge clk);
    set_word(0, 32'h12345678, 2'd3);
    push_word(32'h12345678, 3, 3'b001);
    i_req = 3'b001;
    run("t1");
    do_reset();
    set_word(0, 32'hAA, 2'd0);
    set_word(1, 32'hBB, 2'd0);
    set_word(2, 32'hCC, 2'd0);
    push_word(32'hAA, 0, 3'b001);
    push_word(32'hBB, 0, 3'b010);
    push_word(32'hCC, 0, 3'b100);
    i_req = 3'b111;
    run("t2");
    set_word(1, 32'h11, 2'd0);
    push_word(32'h11, 0, 3'b010);
    i_req = 3'b010;
    run("t3a");
    set_word(1, 32'h33, 2'd0);
    set_word(2, 32'h2244, 2'd1);
    push_word(32'h2244, 1, 3'b100);
    push_word(32'h33, 0, 3'b010);
    i_req = 3'b110;
    run("t3b");
    uart_on = 1'b0;
    set_word(0, 32'hA1B2C3D4, 2'd3);
    exp_b.push_back(8'hA1);
    exp_b.push_back(8'hB2);
    i_req = 3'b001;
    wait_start("t4");
    i_req = 3'b000;
    @(negedge clk);
    pulse_done();
    @(negedge clk);
    chk("t4_wait_2nd", {29'h0, o_state}, 32'h2);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    chk_idle_zero("t4_reset");
    pulse_done();
    chk("t4_stray_state", {29'h0, o_state}, 32'h0);
    chk("t4_drain", exp_b.size(), 32'h0);
    uart_on = 1'b1;
    set_word(0, 32'hA1B2C3D4, 2'd3);
    set_word(1, 32'h77, 2'd0);
    push_word(32'hA1B2C3D4, 3, 3'b001);
    push_word(32'h77, 0, 3'b010);
    i_req = 3'b011;
    run("t4b");
    uart_on = 1'b0;
    pulse_done();
    chk("t5_idle_state", {29'h0, o_state}, 32'h0);
    chk("t5_idle_start", {31'h0, o_tx_start}, 32'h0);
    set_word(2, 32'h5A6B, 2'd1);
    push_word(32'h5A6B, 1, 3'b100);
    i_req = 3'b100;
    wait_start("t5");
    i_req = 3'b000;
    pulse_done();
    chk("t5_send_ignore_state", {29'h0, o_state}, 32'h2);
    chk("t5_send_ignore_data", {24'h0, o_tx_data}, 32'h5A);
    uart_on = 1'b1;
    @(negedge clk);
    pulse_done();
    run("t5");
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
